// File: rtl/alu_op_sequencer_if.sv
// Command/response channel between the CPU control path and alu_op_sequencer.
//   master : CPU side; drives cmd_valid/cmd_op/cmd_a/cmd_b and rsp_ready
//   slave  : sequencer side; drives cmd_ready and rsp_valid/rsp_data/rsp_carry/rsp_err
interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered command front-end for a 16-bit combinational ALU. One transaction in flight:
// accept a command in IDLE, drive the ALU from registers, wait (mul/div only), capture the
// ALU result/carry, then hold the response until it is consumed.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       cmd valid/ready/op/a/b and rsp valid/ready/data/carry/err
//   alu_a/alu_b       registered operands to the ALU
//   alu_select        registered ALU select code
//   alu_out/alu_carry combinational ALU result and a+b carry
//   busy              high whenever the FSM is not idle
//   op_count          count of consumed responses (wraps)
//
// Optional feature: define ALU_SEQ_DIVZERO_EN to flag divide-by-zero (rsp_err=1, data=FFFF).
module alu_op_sequencer #(
  parameter int unsigned MULDIV_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  output logic [2:0]         alu_select,
  input  logic [15:0]        alu_out,
  input  logic               alu_carry,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam logic [3:0] WaitLoad = 4'(MULDIV_WAIT);
  localparam logic [2:0] OpAdd    = 3'b100;
  localparam logic [2:0] OpDiv    = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_sel_q, alu_sel_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic [15:0] count_q, count_d;
`ifdef ALU_SEQ_DIVZERO_EN
  logic        rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    count_d     = count_q;
`ifdef ALU_SEQ_DIVZERO_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          alu_a_d   = bus.cmd_a;
          alu_b_d   = bus.cmd_b;
          alu_sel_d = bus.cmd_op;
          // Ops 110/111 (mul/div) get extra settle cycles.
          wait_d    = (bus.cmd_op[2:1] == 2'b11) ? WaitLoad : 4'd0;
          state_d   = StExec;
        end
      end
      StExec: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          rsp_data_d  = alu_out;
          // The ALU reports a+b carry for every op; it only means something for add.
          rsp_carry_d = (alu_sel_q == OpAdd) && alu_carry;
`ifdef ALU_SEQ_DIVZERO_EN
          if ((alu_sel_q == OpDiv) && (alu_b_q == 16'h0000)) begin
            rsp_data_d = 16'hFFFF;
            rsp_err_d  = 1'b1;
          end else begin
            rsp_err_d  = 1'b0;
          end
`endif
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          count_d = count_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= 4'd0;
      alu_a_q     <= 16'h0000;
      alu_b_q     <= 16'h0000;
      alu_sel_q   <= 3'b000;
      rsp_data_q  <= 16'h0000;
      rsp_carry_q <= 1'b0;
      count_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      count_q     <= count_d;
    end
  end

`ifdef ALU_SEQ_DIVZERO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  // OpDiv is only needed by the divide-by-zero check.
  logic unused_opdiv;
  assign unused_opdiv = ^OpDiv;
  assign bus.rsp_err  = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_select    = alu_sel_q;
  assign busy          = (state_q != StIdle);
  assign op_count      = count_q;

endmodule
